// File: rtl/parking_pkg.sv
// Shared types and constants for the parking access controller front-end.
// Key codes, entry FSM states and the password width live here.
package parking_pkg;

  localparam int PASS_W = 8;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/entry_timeout_counter.sv
// Idle timer for a partial keypad entry: counts enabled cycles and pulses
// expired on the cycle the count reaches TIMEOUT_CYC-1.
module entry_timeout_counter #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  assign expired = enable & (r_count == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= expired ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front-end: accumulates up to MAX_DIGITS decimal digits into an 8-bit
// password and strobes enter_o on ENTER or entry_err_o on an invalid entry.
module keypad_entry
  import parking_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        key_code,
  input  logic              key_valid,
  input  logic              sensor_arrival,
  output logic [PASS_W-1:0] pass_o,
  output logic              enter_o,
  output logic              entry_err_o,
  output logic [1:0]        digits_o
);

  entry_state_t      r_state;
  logic [PASS_W-1:0] r_acc;

  logic        w_key;
  logic        w_digit;
  logic        w_enter;
  logic        w_clear;
  logic        w_in_entry;
  logic [11:0] w_next;
  logic        w_reject;
  logic        w_tmr_en;
  logic        w_tmr_clear;
  logic        w_tmr_expired;

  // Keys only count while a vehicle is present; codes C..F never count.
  assign w_key      = key_valid & sensor_arrival;
  assign w_digit    = w_key & is_digit(key_code);
  assign w_enter    = w_key & (key_code == KEY_ENTER);
  assign w_clear    = w_key & (key_code == KEY_CLEAR);
  assign w_in_entry = (r_state == S_ENTRY);

  assign w_next   = 12'(r_acc) * 12'd10 + 12'(key_code);
  assign w_reject = (digits_o == 2'(MAX_DIGITS)) | (w_next > 12'd255);

  // The timer only runs through idle cycles of an entry; anything else restarts it.
  assign w_tmr_en    = w_in_entry & sensor_arrival & ~(w_digit | w_enter | w_clear);
  assign w_tmr_clear = ~w_tmr_en;

  entry_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_tmr_clear),
    .enable (w_tmr_en),
    .expired(w_tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      pass_o      <= '0;
      enter_o     <= 1'b0;
      entry_err_o <= 1'b0;
      digits_o    <= 2'd0;
    end else begin
      // NOTE: strobes default low each cycle so they are exactly one clock wide.
      enter_o     <= 1'b0;
      entry_err_o <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_digit) begin
            r_acc    <= {4'd0, key_code};
            digits_o <= 2'd1;
            pass_o   <= '0;
            r_state  <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (!sensor_arrival) begin
            r_acc    <= '0;
            digits_o <= 2'd0;
            r_state  <= S_IDLE;
          end else if (w_digit) begin
            if (w_reject) begin
              r_acc       <= '0;
              digits_o    <= 2'd0;
              pass_o      <= '0;
              entry_err_o <= 1'b1;
              r_state     <= S_ERR;
            end else begin
              r_acc    <= w_next[PASS_W-1:0];
              digits_o <= digits_o + 2'd1;
            end
          end else if (w_enter) begin
            pass_o   <= r_acc;
            enter_o  <= 1'b1;
            r_acc    <= '0;
            digits_o <= 2'd0;
            r_state  <= S_DONE;
          end else if (w_clear) begin
            r_acc    <= '0;
            digits_o <= 2'd0;
            pass_o   <= '0;
            r_state  <= S_IDLE;
          end else if (w_tmr_expired) begin
            r_acc    <= '0;
            digits_o <= 2'd0;
            r_state  <= S_IDLE;
          end
        end
        S_DONE,
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_keypad_entry;

  localparam int MAXD = 3;
  localparam int TOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;
  logic       sensor_arrival = 1'b1;
  logic [7:0] pass_o;
  logic       enter_o;
  logic       entry_err_o;
  logic [1:0] digits_o;

  int n_vec  = 0;
  int n_fail = 0;

  keypad_entry #(
    .MAX_DIGITS (MAXD),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .sensor_arrival(sensor_arrival),
    .pass_o        (pass_o),
    .enter_o       (enter_o),
    .entry_err_o   (entry_err_o),
    .digits_o      (digits_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a password is a decimal number typed digit by digit;
  // it is tracked as an integer value, a digit count and cycles since last key.
  int m_pass, m_acc, m_digits, m_idle;
  bit m_enter, m_err, m_active, m_dead, m_ready;

  always @(posedge clk) begin : model_blk
    logic       s_v, s_a, s_r;
    logic [3:0] s_c;
    s_v = key_valid;
    s_a = sensor_arrival;
    s_r = reset;
    s_c = key_code;
    m_enter = 1'b0;
    m_err   = 1'b0;
    if (s_r) begin
      m_pass = 0; m_acc = 0; m_digits = 0; m_idle = 0;
      m_active = 1'b0; m_dead = 1'b0; m_ready = 1'b1;
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (!s_a) begin
      if (m_active) begin
        m_active = 1'b0; m_acc = 0; m_digits = 0;
      end
    end else if (s_v && s_c <= 4'd9) begin
      if (!m_active) begin
        m_active = 1'b1; m_acc = int'(s_c); m_digits = 1; m_pass = 0; m_idle = 0;
      end else if (m_digits == MAXD || m_acc * 10 + int'(s_c) > 255) begin
        m_err = 1'b1; m_dead = 1'b1; m_active = 1'b0;
        m_acc = 0; m_digits = 0; m_pass = 0;
      end else begin
        m_acc = m_acc * 10 + int'(s_c); m_digits++; m_idle = 0;
      end
    end else if (s_v && s_c == 4'hB && m_active) begin
      m_pass = m_acc; m_enter = 1'b1; m_dead = 1'b1;
      m_active = 1'b0; m_acc = 0; m_digits = 0;
    end else if (s_v && s_c == 4'hA && m_active) begin
      m_active = 1'b0; m_acc = 0; m_digits = 0; m_pass = 0;
    end else if (m_active) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_active = 1'b0; m_acc = 0; m_digits = 0;
      end
    end
    #1;
    if (m_ready) begin
      check("model pass_o", pass_o, 8'(m_pass));
      check("model enter_o", {7'd0, enter_o}, {7'd0, m_enter});
      check("model entry_err_o", {7'd0, entry_err_o}, {7'd0, m_err});
      check("model digits_o", {6'd0, digits_o}, 8'(m_digits));
    end
  end

  task automatic cyc(input logic v, input logic [3:0] c, input logic a, input logic r);
    @(negedge clk);
    key_valid      = v;
    key_code       = c;
    sensor_arrival = a;
    reset          = r;
    @(posedge clk);
    #2;
  endtask

  task automatic key(input logic [3:0] c);
    cyc(1'b1, c, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    check("reset pass_o", pass_o, 8'd0);
    check("reset enter_o", {7'd0, enter_o}, 8'd0);
    check("reset entry_err_o", {7'd0, entry_err_o}, 8'd0);
    check("reset digits_o", {6'd0, digits_o}, 8'd0);
    idle(1);

    key(4'd4); key(4'd2);
    check("42 digits", {6'd0, digits_o}, 8'd2);
    key(4'hB);
    check("42 pass_o", pass_o, 8'b00101010);
    check("42 enter_o", {7'd0, enter_o}, 8'd1);
    check("42 digits cleared", {6'd0, digits_o}, 8'd0);
    idle(1);
    check("42 enter drop", {7'd0, enter_o}, 8'd0);
    check("42 pass held", pass_o, 8'd42);

    key(4'd2); key(4'd5); key(4'd6);
    check("256 err", {7'd0, entry_err_o}, 8'd1);
    check("256 pass_o", pass_o, 8'd0);
    idle(1);
    check("256 err drop", {7'd0, entry_err_o}, 8'd0);
    key(4'd2); key(4'd5); key(4'd5); key(4'hB);
    check("255 pass_o", pass_o, 8'd255);
    check("255 enter_o", {7'd0, enter_o}, 8'd1);
    idle(1);

    key(4'd1); key(4'd2); key(4'd3);
    check("123 no err", {7'd0, entry_err_o}, 8'd0);
    key(4'd4);
    check("1234 err", {7'd0, entry_err_o}, 8'd1);
    idle(1);

    key(4'd7); key(4'hA); key(4'hB);
    check("clear enter_o", {7'd0, enter_o}, 8'd0);
    check("clear pass_o", pass_o, 8'd0);

    key(4'd9); idle(TOUT - 1);
    check("pre-timeout digits", {6'd0, digits_o}, 8'd1);
    idle(1);
    check("timeout digits", {6'd0, digits_o}, 8'd0);
    key(4'hB);
    check("timeout enter_o", {7'd0, enter_o}, 8'd0);

    key(4'd3); idle(4); key(4'hC); idle(2);
    check("junk no timer reset", {6'd0, digits_o}, 8'd1);
    idle(1);
    check("junk timeout", {6'd0, digits_o}, 8'd0);

    key(4'd4);
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    check("sensor drop digits", {6'd0, digits_o}, 8'd0);
    key(4'hB);
    check("sensor drop enter_o", {7'd0, enter_o}, 8'd0);
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    check("sensor low digits", {6'd0, digits_o}, 8'd0);

    key(4'd4); key(4'd2);
    cyc(1'b1, 4'hB, 1'b1, 1'b1);
    check("reset mid pass_o", pass_o, 8'd0);
    check("reset mid enter_o", {7'd0, enter_o}, 8'd0);
    check("reset mid digits", {6'd0, digits_o}, 8'd0);
    idle(1);
    check("reset mid no strobe", {7'd0, enter_o}, 8'd0);

    for (int ph = 0; ph < 40; ph++) begin
      int pv;
      pv = (ph % 3 == 0) ? 6 : 60;
      for (int i = 0; i < 60; i++) begin
        logic       v, a, r;
        logic [3:0] c;
        int         sel;
        r   = ($urandom_range(0, 299) == 0);
        a   = ($urandom_range(0, 19) != 0);
        v   = ($urandom_range(0, 99) < pv);
        sel = $urandom_range(0, 99);
        if (sel < 70)      c = 4'($urandom_range(0, 9));
        else if (sel < 85) c = 4'hB;
        else if (sel < 92) c = 4'hA;
        else               c = 4'($urandom_range(12, 15));
        cyc(v, c, a, r);
      end
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
